// File: rtl/vedic_mult_8bit_pipe.sv
// Pipelined 8x8 unsigned Urdhva-Tiryagbhyam multiplier.
// Stage 1 registers the operands, stage 2 registers the four 4x4 Vedic
// partial products, and stage 3 combines them with chained 4-bit
// carry-lookahead cells into the registered product. A single global stall
// (output valid but not accepted) freezes every stage.
module vedic_mult_8bit_pipe #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] p,
  output logic                busy,
  output logic [COUNT_W-1:0]  prod_count
);

  if (DATA_W != 8) begin : g_width_check
    $error("vedic_mult_8bit_pipe supports DATA_W = 8 only");
  end

  // 4-bit carry-lookahead adder cell; returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] t;
    logic [4:0] c;
    g    = x & y;
    t    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (t[0] & ci);
    c[2] = g[1] | (t[1] & g[0]) | (t[1] & t[0] & ci);
    c[3] = g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0])
         | (t[2] & t[1] & t[0] & ci);
    c[4] = g[3] | (t[3] & g[2]) | (t[3] & t[2] & g[1])
         | (t[3] & t[2] & t[1] & g[0]) | (t[3] & t[2] & t[1] & t[0] & ci);
    return {c[4], t ^ c[3:0]};
  endfunction

  // 2x2 Vedic cell: vertical, crosswise, vertical.
  function automatic logic [3:0] mul2x2(input logic [1:0] x,
                                        input logic [1:0] y);
    logic pp00;
    logic pp10;
    logic pp01;
    logic pp11;
    logic cr;
    pp00 = x[0] & y[0];
    pp10 = x[1] & y[0];
    pp01 = x[0] & y[1];
    pp11 = x[1] & y[1];
    cr   = pp10 & pp01;
    return {pp11 & cr, pp11 ^ cr, pp10 ^ pp01, pp00};
  endfunction

  // 4x4 Vedic cell built from four 2x2 cells, same combine scheme as the
  // 8x8 level but on 2-bit halves.
  function automatic logic [7:0] mul4x4(input logic [3:0] x,
                                        input logic [3:0] y);
    logic [3:0] r0;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] r3;
    logic [4:0] t;
    logic [4:0] u;
    logic [4:0] mid;
    logic [4:0] v;
    logic [1:0] top;
    r0  = mul2x2(x[1:0], y[1:0]);
    r1  = mul2x2(x[3:2], y[1:0]);
    r2  = mul2x2(x[1:0], y[3:2]);
    r3  = mul2x2(x[3:2], y[3:2]);
    t   = cla4(r1, r2, 1'b0);
    u   = cla4(t[3:0], {2'b00, r0[3:2]}, 1'b0);
    // mid <= 9+9+3, so the two carries can never both be set
    mid = {t[4] | u[4], u[3:0]};
    v   = cla4({r3[1:0], 2'b00}, mid[3:0], 1'b0);
    top = r3[3:2] + {1'b0, mid[4]} + {1'b0, v[4]};
    return {top, v[3:0], r0[1:0]};
  endfunction

  logic              stall;
  logic              advance;
  logic              accept;
  logic              out_hs;
  logic              s1_valid;
  logic              s2_valid;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [7:0]        q0_r;
  logic [7:0]        q1_r;
  logic [7:0]        q2_r;
  logic [7:0]        q3_r;

  logic [4:0]        m_lo;
  logic [4:0]        m_hi;
  logic [4:0]        n_lo;
  logic [4:0]        n_hi;
  logic [4:0]        h_lo;
  logic [4:0]        h_hi;
  logic [8:0]        sum9;
  logic [8:0]        mid;
  logic [15:0]       prod;
  logic              unused_carry;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign busy     = s1_valid | s2_valid | out_valid;

  // Combine the registered partial products into the 16-bit product.
  always_comb begin
    m_lo = cla4(q1_r[3:0], q2_r[3:0], 1'b0);
    m_hi = cla4(q1_r[7:4], q2_r[7:4], m_lo[4]);
    sum9 = {m_hi[4], m_hi[3:0], m_lo[3:0]};
    n_lo = cla4(sum9[3:0], q0_r[7:4], 1'b0);
    n_hi = cla4(sum9[7:4], 4'b0000, n_lo[4]);
    // q1+q2+q0[7:4] <= 465, so at most one of the two carries is set
    mid  = {sum9[8] | n_hi[4], n_hi[3:0], n_lo[3:0]};
    h_lo = cla4(q3_r[3:0], mid[7:4], 1'b0);
    h_hi = cla4(q3_r[7:4], {3'b000, mid[8]}, h_lo[4]);
    // product fits in 16 bits, so this carry is always zero
    unused_carry = h_hi[4];
    prod = {h_hi[3:0], h_lo[3:0], mid[3:0], q0_r[3:0]};
  end

  // Operand and partial-product registers; contents only matter when the
  // matching valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
      end
      q0_r <= mul4x4(a_r[3:0], b_r[3:0]);
      q1_r <= mul4x4(a_r[7:4], b_r[3:0]);
      q2_r <= mul4x4(a_r[3:0], b_r[7:4]);
      q3_r <= mul4x4(a_r[7:4], b_r[7:4]);
    end
  end

  // Valid pipeline, output product register and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      p          <= '0;
      prod_count <= '0;
    end else begin
      if (advance) begin
        s1_valid  <= accept;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
        if (s2_valid) begin
          p <= prod;
        end
      end
      if (out_hs) begin
        prod_count <= prod_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vedic_mult_8bit_pipe.sv
// Self-checking bench for vedic_mult_8bit_pipe. Inputs are driven and
// outputs sampled just after the falling edge; expected products are queued
// on accept and popped on each output handshake.
module tb_vedic_mult_8bit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;
  logic [15:0] prod_count;

  logic        rst4;
  logic        in_valid4;
  logic        in_ready4;
  logic [7:0]  a4;
  logic [7:0]  b4;
  logic        out_valid4;
  logic        out_ready4;
  logic [15:0] p4;
  logic        busy4;
  logic [3:0]  prod_count4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs    = 0;
  int          hs4   = 0;
  logic [15:0] sb[$];
  logic [15:0] sb4[$];

  always #5 clk = ~clk;

  vedic_mult_8bit_pipe #(.DATA_W(8), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy), .prod_count(prod_count)
  );

  vedic_mult_8bit_pipe #(.DATA_W(8), .COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .busy(busy4), .prod_count(prod_count4)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; rst4 = 1'b1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b1; out_ready4 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    sb.delete(); sb4.delete();
    hs = 0; hs4 = 0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (p !== 16'h0000) begin n_bad++; $display("FAIL reset_p: got %h want 0000", p); end
    n_cmp++; if (prod_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", prod_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || prod_count4 !== 4'd0) begin
      n_bad++; $display("FAIL reset_dut4: got v=%b busy=%b cnt=%0d want 0/0/0", out_valid4, busy4, prod_count4);
    end
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    if (in_valid && in_ready) sb.push_back(16'hFE01);
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = k;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL single_unexpected: got p=%h with empty queue", p);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (p !== e) begin n_bad++; $display("FAIL single_p: got %h want %h", p, e); end
        end
        hs++;
      end
    end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL single_latency: got %0d want 3", lat); end
    @(negedge clk);
    #1;
    n_cmp++; if (prod_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", prod_count); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got v=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  va[3];
    logic [7:0]  vb[3];
    logic [15:0] vp[3];
    int idx;
    int got;
    va = '{8'hA5, 8'h00, 8'h01};
    vb = '{8'h3C, 8'h7B, 8'h80};
    vp = '{16'h26AC, 16'h0000, 16'h0080};
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 3);
      if (idx < 3) begin a = va[idx]; b = vb[idx]; end
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL vectors_unexpected: got p=%h with empty queue", p);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (p !== e) begin n_bad++; $display("FAIL vectors_p: got %h want %h", p, e); end
        end
        got++; hs++;
      end
      if (in_valid && in_ready) begin sb.push_back(vp[idx]); idx++; end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL vectors_timeout: got %0d outputs want 3", got); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va[4];
    logic [7:0]  vb[4];
    logic [15:0] vp[4];
    int idx;
    int got;
    int first_cyc;
    int last_cyc;
    va = '{8'h03, 8'h10, 8'hF0, 8'h80};
    vb = '{8'h05, 8'h10, 8'h0F, 8'h02};
    vp = '{16'h000F, 16'h0100, 16'h0E10, 16'h0100};
    idx = 0; got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 4);
      if (idx < 4) begin a = va[idx]; b = vb[idx]; end
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL b2b_unexpected: got p=%h with empty queue", p);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (p !== e) begin n_bad++; $display("FAIL b2b_p: got %h want %h", p, e); end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++; hs++;
      end
      if (in_valid && in_ready) begin sb.push_back(vp[idx]); idx++; end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL b2b_timeout: got %0d outputs want 4", got); end
    n_cmp++; if (first_cyc != 3) begin n_bad++; $display("FAIL b2b_first_cycle: got %0d want 3", first_cyc); end
    n_cmp++; if (last_cyc - first_cyc != 3) begin
      n_bad++; $display("FAIL b2b_consecutive: got span %0d want 3", last_cyc - first_cyc);
    end
  endtask

  task automatic test_stall();
    logic [7:0]  sa[8];
    logic [7:0]  sv[8];
    logic [15:0] held;
    int stall_left;
    bit stalled;
    int idx;
    int got;
    for (int i = 0; i < 8; i++) begin sa[i] = 8'($urandom); sv[i] = 8'($urandom); end
    held = '0; stall_left = 0; stalled = 1'b0; idx = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 8);
      if (idx < 8) begin a = sa[idx]; b = sv[idx]; end
      if (!stalled && out_valid) begin stalled = 1'b1; stall_left = 5; held = p; end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (p !== held) begin n_bad++; $display("FAIL stall_p_stable: got %h want %h", p, held); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL stall_unexpected: got p=%h with empty queue", p);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (p !== e) begin n_bad++; $display("FAIL stall_order: got %h want %h", p, e); end
        end
        got++; hs++;
      end
      if (in_valid && in_ready) begin
        logic [15:0] m;
        m = {8'h00, a} * {8'h00, b};
        sb.push_back(m);
        idx++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != 8 || sb.size() != 0) begin
      n_bad++; $display("FAIL stall_count: got %0d outputs (%0d pending) want 8 (0)", got, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    int got;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'(i + 3); b = 8'h11; out_ready = 1'b0;
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); hs = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (prod_count !== 16'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", prod_count); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got out_valid=%b p=%h want 0", out_valid, p); end
    end
    for (int cyc = 0; cyc < 20 && got < 1; cyc++) begin
      @(negedge clk);
      in_valid = (cyc == 0);
      a = 8'h07; b = 8'h09; out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL midrst_unexpected: got p=%h with empty queue", p);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (p !== e) begin n_bad++; $display("FAIL midrst_post_p: got %h want %h", p, e); end
        end
        got++; hs++;
      end
      if (in_valid && in_ready) sb.push_back(16'h003F);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (got != 1 || prod_count !== 16'd1) begin
      n_bad++; $display("FAIL midrst_post_count: got outputs=%0d cnt=%0d want 1/1", got, prod_count);
    end
  endtask

  task automatic test_count_wrap();
    int idx;
    int got;
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 17; cyc++) begin
      @(negedge clk);
      in_valid4 = (idx < 17);
      a4 = 8'(idx * 7 + 1); b4 = 8'(idx + 2); out_ready4 = 1'b1;
      #1;
      if (out_valid4 && out_ready4) begin
        n_cmp++;
        if (sb4.size() == 0) begin
          n_bad++; $display("FAIL wrap_unexpected: got p=%h with empty queue", p4);
        end else begin
          logic [15:0] e;
          e = sb4.pop_front();
          if (p4 !== e) begin n_bad++; $display("FAIL wrap_p: got %h want %h", p4, e); end
        end
        got++; hs4++;
      end
      if (in_valid4 && in_ready4) begin
        logic [15:0] m;
        m = {8'h00, a4} * {8'h00, b4};
        sb4.push_back(m);
        idx++;
      end
    end
    in_valid4 = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (got != 17 || prod_count4 !== 4'd1) begin
      n_bad++; $display("FAIL wrap_count: got outputs=%0d cnt=%0d want 17/1", got, prod_count4);
    end
  endtask

  task automatic test_sweep();
    int ia;
    int ib;
    int got;
    int got4;
    ia = 0; ib = 0; got = 0; got4 = 0;
    for (int cyc = 0; cyc < 60000 && (got < 32768 || got4 < 32768); cyc++) begin
      @(negedge clk);
      in_valid  = (ia < 32768);
      a         = 8'(ia >> 8);
      b         = 8'(ia);
      in_valid4 = (ib < 32768);
      a4        = 8'((ib >> 8) + 128);
      b4        = 8'(ib);
      out_ready  = ($urandom_range(0, 7) != 0);
      out_ready4 = ($urandom_range(0, 7) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL sweep_unexpected: got p=%h with empty queue", p);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (p !== e) begin n_bad++; $display("FAIL sweep_p: got %h want %h", p, e); end
        end
        got++; hs++;
      end
      if (out_valid4 && out_ready4) begin
        n_cmp++;
        if (sb4.size() == 0) begin
          n_bad++; $display("FAIL sweep4_unexpected: got p=%h with empty queue", p4);
        end else begin
          logic [15:0] e;
          e = sb4.pop_front();
          if (p4 !== e) begin n_bad++; $display("FAIL sweep4_p: got %h want %h", p4, e); end
        end
        got4++; hs4++;
      end
      if (in_valid && in_ready) begin
        logic [15:0] m;
        m = {8'h00, a} * {8'h00, b};
        sb.push_back(m);
        ia++;
      end
      if (in_valid4 && in_ready4) begin
        logic [15:0] m;
        m = {8'h00, a4} * {8'h00, b4};
        sb4.push_back(m);
        ib++;
      end
    end
    in_valid = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b1; out_ready4 = 1'b1;
    n_cmp++; if (got != 32768 || got4 != 32768) begin
      n_bad++; $display("FAIL sweep_timeout: got %0d/%0d outputs want 32768/32768", got, got4);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (prod_count !== 16'(hs)) begin
      n_bad++; $display("FAIL sweep_count: got %0d want %0d", prod_count, 16'(hs));
    end
    n_cmp++; if (prod_count4 !== 4'(hs4)) begin
      n_bad++; $display("FAIL sweep4_count: got %0d want %0d", prod_count4, 4'(hs4));
    end
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b1; out_ready4 = 1'b1;
    a = '0; b = '0; a4 = '0; b4 = '0;
    test_reset();
    test_single();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_count_wrap();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
